// File: rtl/hex_stopwatch.sv
// hex_stopwatch: MM:SS.hh stopwatch for the six DE-series seven-segment digits.
// The display is updated by a prescaled tick driving cascaded BCD counters.
// Start/stop and clear keys are synchronized and edge-detected.
// lap_hold freezes the display registers while the counters keep running.
//
// Key handshake: each key press produces exactly one pulse (start_p / clear_p).
// The pulse is high for one cycle, in the cycle after the third clock edge that
// sees the key low. The FSM consumes the pulse in that same cycle. There is no
// back-pressure.
module hex_stopwatch #(
    parameter int TICK_DIV = 500000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       key_start_n,
    input  logic       key_clear_n,
    input  logic       lap_hold,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic       running,
    output logic       overflow
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

    state_t            state_q, state_d;
    logic              running_q, running_d;
    logic [2:0]        start_sync_q, start_sync_d;
    logic [2:0]        clear_sync_q, clear_sync_d;
    logic              start_p_q, start_p_d;
    logic              clear_p_q, clear_p_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic              tick;
    logic              clear_all;
    // Packed BCD count {m1, m0, s1, s0, h1, h0}; h0 sits in bits [3:0].
    logic [23:0]       cnt_q, cnt_d;
    logic              overflow_q, overflow_d;
    logic [5:0][6:0]   hex_q, hex_d;

    // Active-low segment code; bit0 = a ... bit6 = g.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Synchronizer shift and falling-edge detection. The bit [2] vs [1] compare
    // places the registered pulse in the cycle after the third edge.
    always_comb begin
        start_sync_d = {start_sync_q[1:0], key_start_n};
        clear_sync_d = {clear_sync_q[1:0], key_clear_n};
        start_p_d    = start_sync_q[2] & ~start_sync_q[1];
        clear_p_d    = clear_sync_q[2] & ~clear_sync_q[1];
    end

    // Next state. A simultaneous clear wins outside RUN; start wins inside RUN.
    always_comb begin
        state_d   = state_q;
        clear_all = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!clear_p_q && start_p_q) state_d = S_RUN;
            end
            S_RUN: begin
                if (start_p_q) state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (clear_p_q) begin
                    state_d   = S_IDLE;
                    clear_all = 1'b1;
                end else if (start_p_q) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        running_d = (state_d == S_RUN);
    end

    // Prescaler. It counts only in RUN, holds in PAUSE, and is zeroed in IDLE or on clear.
    always_comb begin
        tick    = (state_q == S_RUN) && (presc_q == PRESC_MAX);
        presc_d = presc_q;
        if (state_q == S_IDLE || clear_all) begin
            presc_d = '0;
        end else if (state_q == S_RUN) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    // Cascaded BCD counters: hh 00..99, SS 00..59, MM 00..99. Wrapping past
    // 99:59.99 sets the sticky overflow flag.
    always_comb begin
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        if (clear_all) begin
            cnt_d      = '0;
            overflow_d = 1'b0;
        end else if (tick) begin
            if (cnt_q[3:0] != 4'd9) cnt_d[3:0] = cnt_q[3:0] + 4'd1;
            else begin
                cnt_d[3:0] = 4'd0;
                if (cnt_q[7:4] != 4'd9) cnt_d[7:4] = cnt_q[7:4] + 4'd1;
                else begin
                    cnt_d[7:4] = 4'd0;
                    if (cnt_q[11:8] != 4'd9) cnt_d[11:8] = cnt_q[11:8] + 4'd1;
                    else begin
                        cnt_d[11:8] = 4'd0;
                        if (cnt_q[15:12] != 4'd5) cnt_d[15:12] = cnt_q[15:12] + 4'd1;
                        else begin
                            cnt_d[15:12] = 4'd0;
                            if (cnt_q[19:16] != 4'd9) cnt_d[19:16] = cnt_q[19:16] + 4'd1;
                            else begin
                                cnt_d[19:16] = 4'd0;
                                if (cnt_q[23:20] != 4'd9) cnt_d[23:20] = cnt_q[23:20] + 4'd1;
                                else begin
                                    cnt_d[23:20] = 4'd0;
                                    overflow_d   = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    // Display registers follow the counters unless lap_hold freezes them.
    always_comb begin
        hex_d = hex_q;
        if (!lap_hold) begin
            for (int i = 0; i < 6; i++) hex_d[i] = seg7(cnt_q[4*i +: 4]);
        end
    end

    // FSM state and registered running flag.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
        end
    end

    // Key synchronizers, pulses, prescaler, counters and display.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            start_sync_q <= '0;
            clear_sync_q <= '0;
            start_p_q    <= 1'b0;
            clear_p_q    <= 1'b0;
            presc_q      <= '0;
            cnt_q        <= '0;
            overflow_q   <= 1'b0;
            hex_q        <= {6{7'h40}};
        end else begin
            start_sync_q <= start_sync_d;
            clear_sync_q <= clear_sync_d;
            start_p_q    <= start_p_d;
            clear_p_q    <= clear_p_d;
            presc_q      <= presc_d;
            cnt_q        <= cnt_d;
            overflow_q   <= overflow_d;
            hex_q        <= hex_d;
        end
    end

    assign HEX0     = hex_q[0];
    assign HEX1     = hex_q[1];
    assign HEX2     = hex_q[2];
    assign HEX3     = hex_q[3];
    assign HEX4     = hex_q[4];
    assign HEX5     = hex_q[5];
    assign running  = running_q;
    assign overflow = overflow_q;

endmodule
